// File: rtl/taillight_sequencer.sv
// Tail-light sequencing controller: synchronizes the four driver requests,
// resolves them by priority into a lighting mode and steps the three-lamp
// turn animation from an internal step divider.
module taillight_sequencer #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       left_req_i,
  input  logic       right_req_i,
  input  logic       hazard_req_i,
  input  logic       brake_req_i,
  output logic [2:0] lights_l_o,
  output logic [2:0] lights_r_o,
  output logic [2:0] mode_o,
  output logic [1:0] phase_o
);

  typedef enum logic [2:0] {
    ModeIdle       = 3'd0,
    ModeLeft       = 3'd1,
    ModeRight      = 3'd2,
    ModeHazard     = 3'd3,
    ModeBrake      = 3'd4,
    ModeLeftBrake  = 3'd5,
    ModeRightBrake = 3'd6,
    ModeUnused     = 3'd7
  } mode_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TICK_DIV - 1);

  // Request bit positions inside the synchronizer vectors.
  localparam int unsigned ReqLeft   = 0;
  localparam int unsigned ReqRight  = 1;
  localparam int unsigned ReqHazard = 2;
  localparam int unsigned ReqBrake  = 3;

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       req_raw;
  mode_e            mode_q, mode_d, mode_dec;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lights_l_q, lights_l_d;
  logic [2:0]       lights_r_q, lights_r_d;
  logic [2:0]       pattern;
  logic             req_l, req_r, req_h, req_b, both_turn;

  assign req_raw = {brake_req_i, hazard_req_i, right_req_i, left_req_i};

  // Two-stage synchronizer for the asynchronous request levels.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req_raw;
      sync2_q <= sync1_q;
    end
  end

  assign req_l     = sync2_q[ReqLeft];
  assign req_r     = sync2_q[ReqRight];
  assign req_h     = sync2_q[ReqHazard];
  assign req_b     = sync2_q[ReqBrake];
  assign both_turn = req_l & req_r;

  // Priority decode of the synchronized requests; first match wins.
  always_comb begin
    mode_dec = ModeIdle;
    if (req_b && (req_h || both_turn)) begin
      mode_dec = ModeBrake;
    end else if (req_h || both_turn) begin
      mode_dec = ModeHazard;
    end else if (req_l && req_b) begin
      mode_dec = ModeLeftBrake;
    end else if (req_r && req_b) begin
      mode_dec = ModeRightBrake;
    end else if (req_l) begin
      mode_dec = ModeLeft;
    end else if (req_r) begin
      mode_dec = ModeRight;
    end else if (req_b) begin
      mode_dec = ModeBrake;
    end
  end

  // Mode/phase/step-counter next state; a mode change beats a terminal count.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (mode_q == ModeUnused) begin
      mode_d  = ModeIdle;
      phase_d = 2'd0;
      cnt_d   = '0;
    end else if (mode_dec != mode_q) begin
      mode_d  = mode_dec;
      phase_d = 2'd0;
      cnt_d   = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Thermometer animation pattern for the upcoming phase.
  always_comb begin
    pattern = 3'b000;
    unique case (phase_d)
      2'd0: pattern = 3'b000;
      2'd1: pattern = 3'b001;
      2'd2: pattern = 3'b011;
      2'd3: pattern = 3'b111;
      default: pattern = 3'b000;
    endcase
  end

  // Lamp drive from the next-state mode so lamps move on the same edge as mode.
  always_comb begin
    lights_l_d = 3'b000;
    lights_r_d = 3'b000;
    case (mode_d)
      ModeLeft: begin
        lights_l_d = pattern;
      end
      ModeRight: begin
        lights_r_d = pattern;
      end
      ModeHazard: begin
        lights_l_d = pattern;
        lights_r_d = pattern;
      end
      ModeBrake: begin
        lights_l_d = 3'b111;
        lights_r_d = 3'b111;
      end
      ModeLeftBrake: begin
        lights_l_d = pattern;
        lights_r_d = 3'b111;
      end
      ModeRightBrake: begin
        lights_l_d = 3'b111;
        lights_r_d = pattern;
      end
      default: begin
        lights_l_d = 3'b000;
        lights_r_d = 3'b000;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      mode_q     <= ModeIdle;
      phase_q    <= 2'd0;
      cnt_q      <= '0;
      lights_l_q <= 3'b000;
      lights_r_q <= 3'b000;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      lights_l_q <= lights_l_d;
      lights_r_q <= lights_r_d;
    end
  end

  assign lights_l_o = lights_l_q;
  assign lights_r_o = lights_r_q;
  assign mode_o     = mode_q;
  assign phase_o    = phase_q;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Scoreboard bench for taillight_sequencer with a 4-cycle animation step.
module tb_taillight_sequencer;

  logic       clk;
  logic       reset_n;
  logic       left_req, right_req, hazard_req, brake_req;
  logic [2:0] lights_l, lights_r, mode;
  logic [1:0] phase;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  mode;
    logic [1:0]  phase;
    logic [2:0]  l;
    logic [2:0]  r;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int          n_vec;
  int          n_bad;

  taillight_sequencer #(
    .TICK_DIV(4),
    .CNT_W   (3)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .left_req_i  (left_req),
    .right_req_i (right_req),
    .hazard_req_i(hazard_req),
    .brake_req_i (brake_req),
    .lights_l_o  (lights_l),
    .lights_r_o  (lights_r),
    .mode_o      (mode),
    .phase_o     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of rising edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expectation for the sample taken `off` edges after now.
  task automatic push_exp(input int unsigned off, input logic [2:0] m, input logic [1:0] p,
                          input logic [2:0] l, input logic [2:0] r, input string nm);
    exp_t e;
    e.cyc   = cyc + off;
    e.mode  = m;
    e.phase = p;
    e.l     = l;
    e.r     = r;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops every expectation whose sample edge has arrived.
  initial begin
    n_vec = 0;
    n_bad = 0;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        n_vec++;
        if (e.cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: sample at edge %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else if (mode !== e.mode || phase !== e.phase || lights_l !== e.l ||
                     lights_r !== e.r) begin
          n_bad++;
          $display("FAIL %s @%0d: got mode=%0d phase=%0d l=%b r=%b, want mode=%0d phase=%0d l=%b r=%b",
                   e.name, cyc, mode, phase, lights_l, lights_r, e.mode, e.phase, e.l, e.r);
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    left_req   = 1'b1;
    right_req  = 1'b0;
    hazard_req = 1'b0;
    brake_req  = 1'b0;

    // Reset held for 3 edges with left requested; then left turn animation.
    @(negedge clk);
    push_exp(1, 3'd0, 2'd0, 3'b000, 3'b000, "reset_hold_a");
    push_exp(2, 3'd0, 2'd0, 3'b000, 3'b000, "reset_hold_b");
    wait_cyc(2);
    reset_n = 1'b1;
    push_exp(1,  3'd0, 2'd0, 3'b000, 3'b000, "post_reset_1");
    push_exp(2,  3'd0, 2'd0, 3'b000, 3'b000, "post_reset_2");
    push_exp(3,  3'd1, 2'd0, 3'b000, 3'b000, "left_start");
    push_exp(6,  3'd1, 2'd0, 3'b000, 3'b000, "left_ph0_end");
    push_exp(7,  3'd1, 2'd1, 3'b001, 3'b000, "left_ph1");
    push_exp(10, 3'd1, 2'd1, 3'b001, 3'b000, "left_ph1_end");
    push_exp(11, 3'd1, 2'd2, 3'b011, 3'b000, "left_ph2");
    push_exp(15, 3'd1, 2'd3, 3'b111, 3'b000, "left_ph3");
    push_exp(19, 3'd1, 2'd0, 3'b000, 3'b000, "left_wrap");
    wait_cyc(20);

    // Right turn with brake.
    left_req  = 1'b0;
    right_req = 1'b1;
    brake_req = 1'b1;
    push_exp(3,  3'd6, 2'd0, 3'b111, 3'b000, "rbrake_start");
    push_exp(7,  3'd6, 2'd1, 3'b111, 3'b001, "rbrake_ph1");
    push_exp(11, 3'd6, 2'd2, 3'b111, 3'b011, "rbrake_ph2");
    push_exp(15, 3'd6, 2'd3, 3'b111, 3'b111, "rbrake_ph3");
    wait_cyc(16);

    // Hazard plus brake resolves to brake.
    right_req  = 1'b0;
    hazard_req = 1'b1;
    push_exp(3, 3'd4, 2'd0, 3'b111, 3'b111, "haz_brake");
    push_exp(8, 3'd4, 2'd1, 3'b111, 3'b111, "haz_brake_static");
    wait_cyc(9);

    // Drop brake: hazard animates both sides in lockstep from phase 0.
    brake_req = 1'b0;
    push_exp(3,  3'd3, 2'd0, 3'b000, 3'b000, "hazard_start");
    push_exp(7,  3'd3, 2'd1, 3'b001, 3'b001, "hazard_ph1");
    push_exp(11, 3'd3, 2'd2, 3'b011, 3'b011, "hazard_ph2");
    wait_cyc(12);

    // Left+right alone still decodes as hazard, so the animation does not restart.
    hazard_req = 1'b0;
    left_req   = 1'b1;
    right_req  = 1'b1;
    push_exp(3, 3'd3, 2'd3, 3'b111, 3'b111, "lr_hazard_ph3");
    push_exp(7, 3'd3, 2'd0, 3'b000, 3'b000, "lr_hazard_wrap");
    wait_cyc(8);

    // Right turn, then switch to left at phase 2.
    left_req = 1'b0;
    push_exp(3,  3'd2, 2'd0, 3'b000, 3'b000, "right_start");
    push_exp(7,  3'd2, 2'd1, 3'b000, 3'b001, "right_ph1");
    push_exp(11, 3'd2, 2'd2, 3'b000, 3'b011, "right_ph2");
    wait_cyc(11);
    left_req  = 1'b1;
    right_req = 1'b0;
    push_exp(3, 3'd1, 2'd0, 3'b000, 3'b000, "mid_switch");
    push_exp(6, 3'd1, 2'd0, 3'b000, 3'b000, "mid_switch_hold");
    push_exp(7, 3'd1, 2'd1, 3'b001, 3'b000, "mid_switch_ph1");
    wait_cyc(8);

    // Brake during left restarts at phase 0 as LEFT_BRAKE.
    brake_req = 1'b1;
    push_exp(3, 3'd5, 2'd0, 3'b000, 3'b111, "lbrake_start");
    push_exp(7, 3'd5, 2'd1, 3'b001, 3'b111, "lbrake_ph1");
    wait_cyc(8);

    // Hazard to phase 3, then a one-edge reset pulse.
    brake_req  = 1'b0;
    left_req   = 1'b0;
    hazard_req = 1'b1;
    push_exp(3,  3'd3, 2'd0, 3'b000, 3'b000, "haz2_start");
    push_exp(15, 3'd3, 2'd3, 3'b111, 3'b111, "haz2_ph3");
    wait_cyc(15);
    reset_n = 1'b0;
    push_exp(1, 3'd0, 2'd0, 3'b000, 3'b000, "mid_reset");
    wait_cyc(1);
    reset_n = 1'b1;
    push_exp(1, 3'd0, 2'd0, 3'b000, 3'b000, "mid_reset_rel1");
    push_exp(2, 3'd0, 2'd0, 3'b000, 3'b000, "mid_reset_rel2");
    push_exp(3, 3'd3, 2'd0, 3'b000, 3'b000, "haz_resume");
    push_exp(7, 3'd3, 2'd1, 3'b001, 3'b001, "haz_resume_ph1");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never sampled (want edge %0d, now %0d)", e.name, e.cyc, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/taillight_sequencer.md
# taillight_sequencer

Sequencing controller for the tail-light board. It sits between the slide-switch/push-button request inputs and the LEDR drivers. It synchronizes the driver requests, resolves them by priority into a single lighting mode, and sequences the three-lamp-per-side turn animation from an internal step divider. The top level only maps `lights_l`/`lights_r` onto LED pins and `mode` onto the 7-segment decoder.

## Interface
- `TICK_DIV`, default 1000000: clock cycles per animation step. Must be ≥1; 1 means one step per clock.
- `CNT_W`, default 20: width of the step counter. Must satisfy 2^CNT_W ≥ TICK_DIV.

- `clk`  in  1: system clock (10 MHz on board).
- `reset`  in  1: synchronous, active-low.
- `left_req`  in  1: left turn request; asynchronous level.
- `right_req`  in  1: right turn request; asynchronous level.
- `hazard_req`  in  1: hazard request; asynchronous level.
- `brake_req`  in  1: brake request; asynchronous level.
- `lights_l`  out  3: left lamps; bit0 is innermost.
- `lights_r`  out  3: right lamps; bit0 is innermost.
- `mode`  out  3: current mode code.
- `phase`  out  2: current animation phase.

## Operation
- **Input synchronization.** Each `*_req` passes through a 2-FF synchronizer. The synchronizer flops clear to 0 on reset.
- **Mode decode.** Applied to the synchronized requests, first match wins:
  - brake & (hazard | (left & right)) → 4 BRAKE
  - hazard | (left & right) → 3 HAZARD
  - left & brake → 5 LEFT_BRAKE
  - right & brake → 6 RIGHT_BRAKE
  - left → 1 LEFT
  - right → 2 RIGHT
  - brake → 4 BRAKE
  - otherwise → 0 IDLE
  - Code 7 is unused. If it is ever reached, the next edge forces IDLE.
- **State.** `mode` register, `phase` register (0–3), step counter `cnt` (0..TICK_DIV-1).
- **Mode change.** When the decoded mode differs from `mode`:
  - `mode` loads the decoded mode on that edge.
  - `phase` loads 0.
  - `cnt` loads 0.
- **Mode held.**
  - When `cnt`=TICK_DIV-1: `cnt` wraps to 0 and `phase` increments mod 4. The sequence is 3→0, repeating continuously.
  - Otherwise `cnt` increments and `phase` holds.
- **Animation pattern** by phase:
  - phase 0 → 000
  - phase 1 → 001
  - phase 2 → 011
  - phase 3 → 111
- **Lamp outputs per mode.**
  - IDLE: both sides 000.
  - LEFT: `lights_l` = pattern, `lights_r` = 000.
  - RIGHT: `lights_r` = pattern, `lights_l` = 000.
  - HAZARD: both sides = pattern, in lockstep.
  - BRAKE: both sides 111.
  - LEFT_BRAKE: `lights_l` = pattern, `lights_r` = 111.
  - RIGHT_BRAKE: `lights_r` = pattern, `lights_l` = 111.
- **Output registers.** `lights_l`/`lights_r` are registered. They are computed from the next-state `mode` and `phase`, so they update on the same edge as `mode`/`phase`, with no extra cycle.
- **Phase in static modes.** In IDLE and BRAKE, `phase` and `cnt` still run. This has no visible effect.

## Timing
- **Reset.** While `reset`=0 at a rising edge, the following load 0 on that edge: `mode`, `phase`, `cnt`, `lights_l`, `lights_r`, and both synchronizer stages. This holds regardless of request levels, including mid-animation.
- **First edge after reset release.** Decode uses the cleared synchronizer, so `mode` stays 0.
- **Request latency.** A request level stable before edge k is seen as follows:
  - sync stage 1 samples it at edge k;
  - sync stage 2 at edge k+1;
  - `mode`, `phase` and the lamp outputs reflect it after edge k+2.
  - A change is therefore visible 3 edges after the input change.
- **Pulse filtering.** A request pulse narrower than one clock may be missed. No debounce is required; the upstream logic owns debouncing.
- **Step timing.** After a mode change, phase 1 appears exactly TICK_DIV edges later. Each phase then lasts exactly TICK_DIV cycles.
- **Simultaneous events.** A mode change on the same edge as a terminal count takes precedence: `phase` goes to 0, not +1.
- **Brake during a turn.** Toggling brake during LEFT/RIGHT changes the mode code, so the animation restarts at phase 0.

## Test plan
- **Reset.** Hold `reset`=0 for 3 cycles with `left_req`=1; release. Required: all outputs 0 during reset and for 2 edges after release; `mode`=1 and `lights_l`=000 after the 3rd edge.
- **Left turn** (TICK_DIV=4). `left_req`=1. Required: `lights_l` steps 000→001→011→111→000, each value held 4 cycles. `lights_r`=000 throughout.
- **Right turn with brake.** `right_req`=1, `brake_req`=1. Required: `mode`=6, `lights_l`=111 constant, `lights_r` animating.
- **Priority.**
  - `hazard_req`+`brake_req` → `mode`=4, both sides 111.
  - Drop brake → `mode`=3, both sides animate identically from phase 0.
  - `left_req`+`right_req` alone → `mode`=3.
- **Mid-sequence change.** In RIGHT at phase 2, switch to left only. Required: 3 edges later `mode`=1, `phase`=0, `lights_l`=000, `lights_r`=000. `lights_l`=001 comes 4 cycles after that.
- **Reset mid-animation.** In HAZARD at phase 3, pull `reset`=0 for 1 edge. Required: next edge gives `mode`=0, `phase`=0, both sides 000. After release, HAZARD resumes 3 edges later at phase 0.
